pipeline_hazard_ctrl: RTL and testbench

Central stall/flush/redirect controller for the 5-stage MIPS pipeline.
- Detects load-use hazards between ID and EX, which the forwarding network cannot resolve.
- Acts on EX-stage branch mispredictions and freezes the pipeline while data memory is busy.
- Sequences program halt: drains in-flight instructions, then parks the front end.
- Keeps saturating performance counters for stalls, flushes and cycles.

---
 rtl/pipeline_hazard_ctrl.sv | 157 +++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - stall/flush/redirect/halt controller for the 5-stage pipeline
module pipeline_hazard_ctrl #(
   parameter int CNT_W        = 32,
   parameter int DRAIN_CYCLES = 3
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [4:0]       i_id_rs,
   input  logic [4:0]       i_id_rt,
   input  logic             i_id_uses_rt,
   input  logic             i_id_halt,
   input  logic             i_ex_mem_read,
   input  logic [4:0]       i_ex_rt,
   input  logic             i_ex_mispredicted,
   input  logic             i_ex_branch_taken,
   input  logic [31:0]      i_ex_branch_target,
   input  logic [31:0]      i_ex_pc_plus4,
   input  logic             i_mem_busy,
   output logic             o_pc_write,
   output logic             o_if_id_write,
   output logic             o_if_id_flush,
   output logic             o_id_ex_write,
   output logic             o_id_ex_flush,
   output logic             o_ex_mem_write,
   output logic             o_pc_redirect,
   output logic [31:0]      o_redirect_addr,
   output logic             o_halted,
   output logic [CNT_W-1:0] o_stall_cycles,
   output logic [CNT_W-1:0] o_flush_count,
   output logic [CNT_W-1:0] o_cycle_count
);

   // Drain counter must hold DRAIN_CYCLES itself.
   localparam int DW = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES + 1);

   typedef enum logic [1:0] {
      ST_RUN    = 2'd0,
      ST_DRAIN  = 2'd1,
      ST_HALTED = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [DW-1:0]     drain_q, drain_d;
   logic [CNT_W-1:0]  stall_q, flush_q, cycle_q;
   logic              stall_inc, flush_inc;
   logic              load_use;

   // A load in EX whose destination feeds the ID instruction cannot be forwarded in time.
   always_comb begin
      load_use = i_ex_mem_read && (i_ex_rt != 5'd0) &&
                 ((i_ex_rt == i_id_rs) || (i_id_uses_rt && (i_ex_rt == i_id_rt)));
   end

   // Pipeline control outputs and next state; reset cycle forces RUN defaults.
   always_comb begin
      o_pc_write      = 1'b1;
      o_if_id_write   = 1'b1;
      o_if_id_flush   = 1'b0;
      o_id_ex_write   = 1'b1;
      o_id_ex_flush   = 1'b0;
      o_ex_mem_write  = 1'b1;
      o_pc_redirect   = 1'b0;
      o_redirect_addr = 32'd0;
      o_halted        = 1'b0;
      state_d         = state_q;
      drain_d         = drain_q;
      stall_inc       = 1'b0;
      flush_inc       = 1'b0;

      if (!reset) begin
         case (state_q)
            ST_RUN, ST_DRAIN: begin
               if (i_mem_busy) begin
                  // Freeze everything; a pending mispredict is serviced once memory is ready.
                  o_pc_write     = 1'b0;
                  o_if_id_write  = 1'b0;
                  o_id_ex_write  = 1'b0;
                  o_ex_mem_write = 1'b0;
               end else begin
                  if (i_ex_mispredicted) begin
                     // The ID instruction is squashed, so its hazards and halt do not matter.
                     o_pc_redirect   = 1'b1;
                     o_redirect_addr = i_ex_branch_taken ? i_ex_branch_target : i_ex_pc_plus4;
                     o_if_id_flush   = 1'b1;
                     o_id_ex_flush   = 1'b1;
                     flush_inc       = 1'b1;
                  end else if (load_use) begin
                     // One bubble suffices: the load reaches MEM next cycle and forwards from there.
                     o_pc_write    = 1'b0;
                     o_if_id_write = 1'b0;
                     o_id_ex_flush = 1'b1;
                     stall_inc     = 1'b1;
                  end else if ((state_q == ST_RUN) && i_id_halt) begin
                     // HALT proceeds into EX; nothing younger is allowed behind it.
                     o_pc_write    = 1'b0;
                     o_if_id_flush = 1'b1;
                     state_d       = ST_DRAIN;
                     drain_d       = DW'(DRAIN_CYCLES);
                  end

                  if (state_q == ST_DRAIN) begin
                     // Front end stays parked while EX, MEM and WB retire.
                     o_pc_write    = 1'b0;
                     o_if_id_flush = 1'b1;
                     if (drain_q <= DW'(1)) begin
                        state_d = ST_HALTED;
                        drain_d = '0;
                     end else begin
                        drain_d = drain_q - DW'(1);
                     end
                  end
               end
            end

            ST_HALTED: begin
               o_pc_write    = 1'b0;
               o_if_id_write = 1'b0;
               o_id_ex_flush = 1'b1;
               o_halted      = 1'b1;
            end

            default: begin
               state_d = ST_RUN;
               drain_d = '0;
            end
         endcase
      end
   end

   // State, drain counter and saturating performance counters.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_RUN;
         drain_q <= '0;
         stall_q <= '0;
         flush_q <= '0;
         cycle_q <= '0;
      end else begin
         state_q <= state_d;
         drain_q <= drain_d;
         if ((state_q != ST_HALTED) && (cycle_q != {CNT_W{1'b1}})) begin
            cycle_q <= cycle_q + CNT_W'(1);
         end
         if (stall_inc && (stall_q != {CNT_W{1'b1}})) begin
            stall_q <= stall_q + CNT_W'(1);
         end
         if (flush_inc && (flush_q != {CNT_W{1'b1}})) begin
            flush_q <= flush_q + CNT_W'(1);
         end
      end
   end

   assign o_stall_cycles = stall_q;
   assign o_flush_count  = flush_q;
   assign o_cycle_count  = cycle_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - scoreboard bench for pipeline_hazard_ctrl
module tb_pipeline_hazard_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset = 1'b1;
   logic [4:0]  id_rs = '0, id_rt = '0, ex_rt = '0;
   logic        id_uses_rt = 1'b0, id_halt = 1'b0, ex_mem_read = 1'b0;
   logic        ex_misp = 1'b0, ex_taken = 1'b0, mem_busy = 1'b0;
   logic [31:0] ex_target = '0, ex_pc4 = '0;

   logic        pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush, ex_mem_write, pc_redirect, halted;
   logic [31:0] redirect_addr, stall_cycles, flush_count, cycle_count;

   logic        s_pc_write, s_if_id_write, s_if_id_flush, s_id_ex_write, s_id_ex_flush, s_ex_mem_write, s_pc_redirect, s_halted;
   logic [31:0] s_redirect_addr;
   logic [3:0]  s_stall_cycles, s_flush_count, s_cycle_count;

   pipeline_hazard_ctrl #(.CNT_W(32), .DRAIN_CYCLES(3)) u_dut (
      .clk(clk), .reset(reset),
      .i_id_rs(id_rs), .i_id_rt(id_rt), .i_id_uses_rt(id_uses_rt), .i_id_halt(id_halt),
      .i_ex_mem_read(ex_mem_read), .i_ex_rt(ex_rt), .i_ex_mispredicted(ex_misp),
      .i_ex_branch_taken(ex_taken), .i_ex_branch_target(ex_target), .i_ex_pc_plus4(ex_pc4),
      .i_mem_busy(mem_busy),
      .o_pc_write(pc_write), .o_if_id_write(if_id_write), .o_if_id_flush(if_id_flush),
      .o_id_ex_write(id_ex_write), .o_id_ex_flush(id_ex_flush), .o_ex_mem_write(ex_mem_write),
      .o_pc_redirect(pc_redirect), .o_redirect_addr(redirect_addr), .o_halted(halted),
      .o_stall_cycles(stall_cycles), .o_flush_count(flush_count), .o_cycle_count(cycle_count)
   );

   pipeline_hazard_ctrl #(.CNT_W(4), .DRAIN_CYCLES(3)) u_sat (
      .clk(clk), .reset(reset),
      .i_id_rs(id_rs), .i_id_rt(id_rt), .i_id_uses_rt(id_uses_rt), .i_id_halt(id_halt),
      .i_ex_mem_read(ex_mem_read), .i_ex_rt(ex_rt), .i_ex_mispredicted(ex_misp),
      .i_ex_branch_taken(ex_taken), .i_ex_branch_target(ex_target), .i_ex_pc_plus4(ex_pc4),
      .i_mem_busy(mem_busy),
      .o_pc_write(s_pc_write), .o_if_id_write(s_if_id_write), .o_if_id_flush(s_if_id_flush),
      .o_id_ex_write(s_id_ex_write), .o_id_ex_flush(s_id_ex_flush), .o_ex_mem_write(s_ex_mem_write),
      .o_pc_redirect(s_pc_redirect), .o_redirect_addr(s_redirect_addr), .o_halted(s_halted),
      .o_stall_cycles(s_stall_cycles), .o_flush_count(s_flush_count), .o_cycle_count(s_cycle_count)
   );

   typedef struct {
      logic        reset;
      logic [4:0]  rs, rt;
      logic        uses_rt, halt, mr;
      logic [4:0]  ex_rt;
      logic        misp, taken;
      logic [31:0] tgt, pc4;
      logic        busy;
   } vec_t;

   typedef struct {
      string       name;
      logic [6:0]  ctl;
      logic [31:0] addr;
      logic        halted;
      logic [31:0] stall, flush, cyc;
      logic [3:0]  stall4;
   } exp_t;

   // ctl order: {pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush, ex_mem_write, pc_redirect}
   localparam logic [6:0] CTL_RUN    = 7'b1101010;
   localparam logic [6:0] CTL_STALL  = 7'b0001110;
   localparam logic [6:0] CTL_MISP   = 7'b1111111;
   localparam logic [6:0] CTL_BUSY   = 7'b0000000;
   localparam logic [6:0] CTL_DRAIN  = 7'b0111010;
   localparam logic [6:0] CTL_HALTED = 7'b0001110;

   exp_t        sb[$];
   int          n_tests = 0;
   int          n_fail  = 0;
   logic [31:0] m_stall = 0, m_flush = 0, m_cyc = 0;
   logic [3:0]  m_stall4 = 0;

   function automatic vec_t v_idle();
      vec_t v;
      v = '{default: '0};
      return v;
   endfunction

   task automatic chk(input string nm, input string field, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s.%s: got 0x%0h expected 0x%0h", nm, field, act, exp);
      end
   endtask

   task automatic step(input string name, input vec_t v, input logic [6:0] ctl, input logic [31:0] addr,
                       input logic hlt, input bit inc_s, input bit inc_f);
      exp_t e;
      @(posedge clk);
      #1;
      reset = v.reset; id_rs = v.rs; id_rt = v.rt; id_uses_rt = v.uses_rt; id_halt = v.halt;
      ex_mem_read = v.mr; ex_rt = v.ex_rt; ex_misp = v.misp; ex_taken = v.taken;
      ex_target = v.tgt; ex_pc4 = v.pc4; mem_busy = v.busy;
      e.name = name; e.ctl = ctl; e.addr = addr; e.halted = hlt;
      e.stall = m_stall; e.flush = m_flush; e.cyc = m_cyc; e.stall4 = m_stall4;
      sb.push_back(e);
      if (v.reset) begin
         m_stall = 0; m_flush = 0; m_cyc = 0; m_stall4 = 0;
      end else begin
         if (!hlt) m_cyc = m_cyc + 1;
         if (inc_s) begin
            m_stall = m_stall + 1;
            if (m_stall4 != 4'hF) m_stall4 = m_stall4 + 1;
         end
         if (inc_f) m_flush = m_flush + 1;
      end
   endtask

   // Monitor: compares the DUT against the oldest expectation each cycle.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            chk(e.name, "ctl", 32'({pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush, ex_mem_write, pc_redirect}), 32'(e.ctl));
            chk(e.name, "addr", redirect_addr, e.addr);
            chk(e.name, "halted", 32'(halted), 32'(e.halted));
            chk(e.name, "stall", stall_cycles, e.stall);
            chk(e.name, "flush", flush_count, e.flush);
            chk(e.name, "cycle", cycle_count, e.cyc);
            chk(e.name, "sat_ctl", 32'({s_pc_write, s_if_id_write, s_if_id_flush, s_id_ex_write, s_id_ex_flush, s_ex_mem_write, s_pc_redirect, s_halted}), 32'({e.ctl, e.halted}));
            chk(e.name, "sat_stall", 32'(s_stall_cycles), 32'(e.stall4));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t v;
      v = v_idle(); v.reset = 1'b1;
      step("reset", v, CTL_RUN, 32'h0, 1'b0, 1'b0, 1'b0);
      v = v_idle();
      step("idle0", v, CTL_RUN, 32'h0, 1'b0, 1'b0, 1'b0);

      v = v_idle(); v.mr = 1'b1; v.ex_rt = 5'd5; v.rs = 5'd5;
      step("lu_rs", v, CTL_STALL, 32'h0, 1'b0, 1'b1, 1'b0);
      v = v_idle();
      step("after_lu", v, CTL_RUN, 32'h0, 1'b0, 1'b0, 1'b0);
      v = v_idle(); v.mr = 1'b1; v.ex_rt = 5'd0; v.rs = 5'd0;
      step("lu_r0", v, CTL_RUN, 32'h0, 1'b0, 1'b0, 1'b0);
      v = v_idle(); v.mr = 1'b1; v.ex_rt = 5'd7; v.rs = 5'd3; v.rt = 5'd7; v.uses_rt = 1'b1;
      step("lu_rt", v, CTL_STALL, 32'h0, 1'b0, 1'b1, 1'b0);
      v.uses_rt = 1'b0;
      step("lu_rt_unused", v, CTL_RUN, 32'h0, 1'b0, 1'b0, 1'b0);

      v = v_idle(); v.misp = 1'b1; v.taken = 1'b1; v.tgt = 32'h40; v.pc4 = 32'h24;
      step("misp_taken", v, CTL_MISP, 32'h40, 1'b0, 1'b0, 1'b1);
      v = v_idle(); v.misp = 1'b1; v.taken = 1'b0; v.tgt = 32'h40; v.pc4 = 32'h1C;
      step("misp_ntaken", v, CTL_MISP, 32'h1C, 1'b0, 1'b0, 1'b1);
      v = v_idle(); v.misp = 1'b1; v.taken = 1'b1; v.tgt = 32'h80; v.pc4 = 32'h30;
      v.mr = 1'b1; v.ex_rt = 5'd5; v.rs = 5'd5; v.halt = 1'b1;
      step("misp_lu_halt", v, CTL_MISP, 32'h80, 1'b0, 1'b0, 1'b1);
      v = v_idle();
      step("still_run", v, CTL_RUN, 32'h0, 1'b0, 1'b0, 1'b0);

      v = v_idle(); v.misp = 1'b1; v.taken = 1'b1; v.tgt = 32'h100; v.pc4 = 32'h50; v.busy = 1'b1;
      for (int i = 0; i < 4; i++) step("busy_misp", v, CTL_BUSY, 32'h0, 1'b0, 1'b0, 1'b0);
      v.busy = 1'b0;
      step("misp_after_busy", v, CTL_MISP, 32'h100, 1'b0, 1'b0, 1'b1);
      v = v_idle();
      step("idle1", v, CTL_RUN, 32'h0, 1'b0, 1'b0, 1'b0);

      v = v_idle(); v.halt = 1'b1;
      step("halt_id", v, CTL_DRAIN, 32'h0, 1'b0, 1'b0, 1'b0);
      v = v_idle();
      step("drain1", v, CTL_DRAIN, 32'h0, 1'b0, 1'b0, 1'b0);
      v.busy = 1'b1;
      step("drain_busy", v, CTL_BUSY, 32'h0, 1'b0, 1'b0, 1'b0);
      v.busy = 1'b0;
      step("drain2", v, CTL_DRAIN, 32'h0, 1'b0, 1'b0, 1'b0);
      step("drain3", v, CTL_DRAIN, 32'h0, 1'b0, 1'b0, 1'b0);
      step("halted", v, CTL_HALTED, 32'h0, 1'b1, 1'b0, 1'b0);
      v.busy = 1'b1; v.misp = 1'b1; v.taken = 1'b1; v.tgt = 32'h200;
      step("halted_hold", v, CTL_HALTED, 32'h0, 1'b1, 1'b0, 1'b0);

      v = v_idle(); v.reset = 1'b1;
      step("reset2", v, CTL_RUN, 32'h0, 1'b0, 1'b0, 1'b0);
      v = v_idle();
      step("post_reset", v, CTL_RUN, 32'h0, 1'b0, 1'b0, 1'b0);

      for (int i = 0; i < 20; i++) begin
         v = v_idle(); v.mr = 1'b1; v.ex_rt = 5'd9; v.rs = 5'd9;
         step("sat_lu", v, CTL_STALL, 32'h0, 1'b0, 1'b1, 1'b0);
         v = v_idle();
         step("sat_gap", v, CTL_RUN, 32'h0, 1'b0, 1'b0, 1'b0);
      end
      step("final", v, CTL_RUN, 32'h0, 1'b0, 1'b0, 1'b0);

      for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
      #1;
      n_tests++;
      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL drain_scoreboard: got %0d pending expected 0", sb.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
